hw_mailbox_responder: RTL and testbench

Hardware-side responder for the software mailbox in the Nios system. Software writes sixteen 32-bit words and raises a 2-bit request on to_hw_sig. This block copies the words into a shadow bank and swaps them into an active bank that the game/video logic reads. It reports completion and status back through to_sw_sig and the to_sw result words, using a four-phase request/acknowledge handshake.

---
 rtl/hw_mailbox_responder.sv | 186 ++++++++++++++++++
 tb/tb_hw_mailbox_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hw_mailbox_responder.sv
// hw_mailbox_responder: hardware side of the Nios software mailbox.
// Copies NUM_WORDS request words into a shadow bank, swaps them into the
// active bank read by the game/video logic, and reports status back to
// software through a four-phase request/acknowledge handshake.
// Optional build macro FRAME_SYNC_SWAP_EN: when defined, the shadow->active
// swap waits for the next frame_start (tear-free); otherwise it follows the
// copy immediately.
module hw_mailbox_responder #(
  parameter int NUM_WORDS = 16,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 8
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [1:0]                  to_hw_sig,
  input  logic [NUM_WORDS*WORD_W-1:0] to_hw_words,
  input  logic                        frame_start,
  output logic [1:0]                  to_sw_sig,
  output logic [31:0]                 to_sw_port0,
  output logic [31:0]                 to_sw_port1,
  output logic [CNT_W-1:0]            to_sw_port2,
  output logic [15:0]                 to_sw_port3,
  output logic [15:0]                 to_sw_port4,
  output logic [NUM_WORDS*WORD_W-1:0] active_words,
  output logic                        swap_pulse
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // State encoding is visible to software through to_sw_port4.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COPY      = 3'd1;
  localparam logic [2:0] ST_WAIT_SWAP = 3'd2;
  localparam logic [2:0] ST_SWAP      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERR       = 3'd5;

  logic [1:0]        sig_q, sig_d;
  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] chk_q, chk_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic [31:0]       port0_q, port0_d;
  logic [31:0]       port1_q, port1_d;
  logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0] shadow_q [NUM_WORDS];
  logic [WORD_W-1:0] shadow_d [NUM_WORDS];
  logic [WORD_W-1:0] active_q [NUM_WORDS];
  logic [WORD_W-1:0] active_d [NUM_WORDS];
  logic [WORD_W-1:0] in_word  [NUM_WORDS];

  // Unpack the flattened request words and pack the active bank.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign in_word[gi] = to_hw_words[gi*WORD_W +: WORD_W];
      assign active_words[gi*WORD_W +: WORD_W] = active_q[gi];
    end
  endgenerate

  assign to_sw_port0 = port0_q;
  assign to_sw_port1 = port1_q;
  assign to_sw_port2 = commit_cnt_q;
  assign to_sw_port3 = err_cnt_q;
  assign to_sw_port4 = {13'b0, state_q};
  assign swap_pulse  = (state_q == ST_SWAP);

  // Response code is a pure function of state so reset clears it at once.
  always_comb begin
    to_sw_sig = 2'b00;
    case (state_q)
      ST_COPY, ST_WAIT_SWAP, ST_SWAP: to_sw_sig = 2'b01;
      ST_DONE:                        to_sw_sig = 2'b10;
      ST_ERR:                         to_sw_sig = 2'b11;
      default:                        to_sw_sig = 2'b00;
    endcase
  end

  // Next-state logic; outside IDLE only a drop to 00 on sig_q is acted on.
  always_comb begin
    sig_d        = to_hw_sig;
    state_d      = state_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    frame_cnt_d  = frame_cnt_q + {31'b0, frame_start};
    port0_d      = port0_q;
    port1_d      = port1_q;
    commit_cnt_d = commit_cnt_q;
    err_cnt_d    = err_cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    case (state_q)
      ST_IDLE: begin
        case (sig_q)
          2'b01: begin
            idx_d   = '0;
            chk_d   = '0;
            state_d = ST_COPY;
          end
          2'b10: begin
            port1_d = frame_cnt_q;
            state_d = ST_DONE;
          end
          2'b11: begin
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
            state_d = ST_ERR;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_COPY: begin
        if (sig_q == 2'b00) begin
          // Abort: partial shadow contents are simply left behind.
          state_d = ST_IDLE;
        end else begin
          shadow_d[idx_q] = in_word[idx_q];
          chk_d           = chk_q ^ in_word[idx_q];
          if (idx_q == LAST_IDX) begin
`ifdef FRAME_SYNC_SWAP_EN
            state_d = ST_WAIT_SWAP;
`else
            state_d = ST_SWAP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_WAIT_SWAP: begin
        // Only a frame_start seen in this state triggers the swap.
        if (sig_q == 2'b00) begin
          state_d = ST_IDLE;
        end else if (frame_start) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        active_d     = shadow_q;
        port0_d      = chk_q;
        commit_cnt_d = commit_cnt_q + 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE, ST_ERR: begin
        if (sig_q == 2'b00) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sig_q        <= 2'b00;
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      chk_q        <= '0;
      frame_cnt_q  <= '0;
      port0_q      <= '0;
      port1_q      <= '0;
      commit_cnt_q <= '0;
      err_cnt_q    <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      sig_q        <= sig_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      frame_cnt_q  <= frame_cnt_d;
      port0_q      <= port0_d;
      port1_q      <= port1_d;
      commit_cnt_q <= commit_cnt_d;
      err_cnt_q    <= err_cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

endmodule

// File: tb/tb_hw_mailbox_responder.sv
// Self-checking bench for hw_mailbox_responder (default NUM_WORDS=16).
// Works with or without FRAME_SYNC_SWAP_EN defined.
module tb_hw_mailbox_responder;

  localparam int NW = 16;
  localparam int WW = 32;
  localparam int CW = 8;
  localparam int VW = NW * WW;
`ifdef FRAME_SYNC_SWAP_EN
  localparam int DONE_K = 27;
`else
  localparam int DONE_K = 1 + (1 + NW + 1);
`endif

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [1:0]    to_hw_sig;
  logic [VW-1:0] to_hw_words;
  logic          frame_start;
  logic [1:0]    to_sw_sig;
  logic [31:0]   to_sw_port0;
  logic [31:0]   to_sw_port1;
  logic [CW-1:0] to_sw_port2;
  logic [15:0]   to_sw_port3;
  logic [15:0]   to_sw_port4;
  logic [VW-1:0] active_words;
  logic          swap_pulse;

  always #5 clk_clk = ~clk_clk;

  hw_mailbox_responder #(.NUM_WORDS(NW), .WORD_W(WW), .CNT_W(CW)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .to_hw_sig    (to_hw_sig),
    .to_hw_words  (to_hw_words),
    .frame_start  (frame_start),
    .to_sw_sig    (to_sw_sig),
    .to_sw_port0  (to_sw_port0),
    .to_sw_port1  (to_sw_port1),
    .to_sw_port2  (to_sw_port2),
    .to_sw_port3  (to_sw_port3),
    .to_sw_port4  (to_sw_port4),
    .active_words (active_words),
    .swap_pulse   (swap_pulse)
  );

  int total = 0;
  int bad   = 0;
  int swap_cnt = 0;

  // Reference model state.
  logic [WW-1:0] m_active [NW];
  logic [WW-1:0] cur      [NW];
  logic [WW-1:0] m_chk;
  int            m_commits;
  int unsigned   m_frames;
  int            m_errs;

  always @(negedge clk_clk) if (swap_pulse === 1'b1) swap_cnt++;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_bank();
    logic [VW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*WW +: WW] = m_active[i];
    return v;
  endfunction

  function automatic logic [WW-1:0] cur_xor();
    logic [WW-1:0] x = '0;
    for (int i = 0; i < NW; i++) x ^= cur[i];
    return x;
  endfunction

  task automatic drive_words();
    for (int i = 0; i < NW; i++) to_hw_words[i*WW +: WW] = cur[i];
  endtask

  task automatic random_words();
    for (int i = 0; i < NW; i++) cur[i] = $urandom;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) m_active[i] = '0;
    m_chk = '0; m_commits = 0; m_frames = 0; m_errs = 0;
  endtask

  // Full commit: drives cur[], waits (bounded) for done, checks, releases.
  task automatic do_commit(input string tag);
    int k = 0;
    bit seen_busy = 0;
    bit done = 0;
    int start_swaps = swap_cnt;
    logic [CW-1:0] exp_cnt;
    drive_words();
    to_hw_sig = 2'b01;
    while (!done && k < 100) begin
      @(negedge clk_clk);
      k++;
      frame_start = 1'b0;
      if (to_sw_sig === 2'b01) seen_busy = 1;
      if (to_sw_sig === 2'b10) done = 1;
      else if (k == 12) begin frame_start = 1'b1; m_frames++; end
`ifdef FRAME_SYNC_SWAP_EN
      else if (k == 25) begin frame_start = 1'b1; m_frames++; end
`endif
    end
    frame_start = 1'b0;
    for (int i = 0; i < NW; i++) m_active[i] = cur[i];
    m_chk = cur_xor();
    m_commits++;
    exp_cnt = CW'(m_commits);
    check({tag, "_done"}, VW'(done), VW'(1));
    check({tag, "_busy"}, VW'(seen_busy), VW'(1));
    check({tag, "_latency"}, VW'(k), VW'(DONE_K));
    check({tag, "_active"}, active_words, model_bank());
    check({tag, "_chk"}, VW'(to_sw_port0), VW'(m_chk));
    check({tag, "_cnt"}, VW'(to_sw_port2), VW'(exp_cnt));
    check({tag, "_swaps"}, VW'(swap_cnt - start_swaps), VW'(1));
    check({tag, "_dbg"}, VW'(to_sw_port4), VW'(4));
    to_hw_sig = 2'b00;
    @(negedge clk_clk);
    check({tag, "_hold"}, VW'(to_sw_sig), VW'(2'b10));
    @(negedge clk_clk);
    check({tag, "_idle"}, VW'(to_sw_sig), VW'(2'b00));
    $display("commit %s words[5]=%h chk=%h cnt=%0d latency=%0d", tag, cur[5], m_chk, exp_cnt, k);
  endtask

  initial begin
    int start_swaps;
    reset_reset_n = 1'b0;
    to_hw_sig = 2'b00;
    to_hw_words = '0;
    frame_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_clk);
    check("rst_sig", VW'(to_sw_sig), VW'(0));
    check("rst_port0", VW'(to_sw_port0), VW'(0));
    check("rst_port2", VW'(to_sw_port2), VW'(0));
    check("rst_port4", VW'(to_sw_port4), VW'(0));
    check("rst_active", active_words, model_bank());
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Status snapshot after seven frame pulses.
    repeat (7) begin
      frame_start = 1'b1; m_frames++;
      @(negedge clk_clk);
      frame_start = 1'b0;
      @(negedge clk_clk);
    end
    to_hw_sig = 2'b10;
    @(negedge clk_clk);
    check("status_lat1", VW'(to_sw_sig), VW'(2'b00));
    @(negedge clk_clk);
    check("status_sig", VW'(to_sw_sig), VW'(2'b10));
    check("status_frames", VW'(to_sw_port1), VW'(m_frames));
    check("status_active", active_words, model_bank());
    to_hw_sig = 2'b00;
    repeat (2) @(negedge clk_clk);
    check("status_idle", VW'(to_sw_sig), VW'(2'b00));
    $display("status frames=%0d port1=%0d", m_frames, to_sw_port1);

    // Commit of the incrementing pattern.
    for (int i = 0; i < NW; i++) cur[i] = 32'h1000_0000 + i;
    do_commit("pattern");

    // Reserved request.
    to_hw_sig = 2'b11; m_errs++;
    repeat (2) @(negedge clk_clk);
    check("rsv_sig", VW'(to_sw_sig), VW'(2'b11));
    check("rsv_errs", VW'(to_sw_port3), VW'(m_errs));
    check("rsv_dbg", VW'(to_sw_port4), VW'(5));
    to_hw_sig = 2'b00;
    repeat (2) @(negedge clk_clk);
    check("rsv_idle", VW'(to_sw_sig), VW'(2'b00));
    $display("reserved errs=%0d", to_sw_port3);
    random_words();
    do_commit("after_rsv");

    // Abort while copying word 8.
    start_swaps = swap_cnt;
    random_words();
    drive_words();
    to_hw_sig = 2'b01;
    repeat (10) @(negedge clk_clk);
    check("abort_busy", VW'(to_sw_sig), VW'(2'b01));
    to_hw_sig = 2'b00;
    repeat (2) @(negedge clk_clk);
    check("abort_idle", VW'(to_sw_sig), VW'(2'b00));
    repeat (3) @(negedge clk_clk);
    check("abort_swaps", VW'(swap_cnt - start_swaps), VW'(0));
    check("abort_active", active_words, model_bank());
    check("abort_cnt", VW'(to_sw_port2), VW'(CW'(m_commits)));
    check("abort_chk", VW'(to_sw_port0), VW'(m_chk));
    $display("abort at idx 8 cnt=%0d", to_sw_port2);

    // Commit counter wrap.
    while (m_commits < 256) begin
      random_words();
      do_commit("wrap");
    end
    check("wrap_zero", VW'(to_sw_port2), VW'(0));

    // Asynchronous reset in the middle of a copy.
    random_words();
    drive_words();
    to_hw_sig = 2'b01;
    repeat (8) @(negedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_sig", VW'(to_sw_sig), VW'(0));
    check("arst_port0", VW'(to_sw_port0), VW'(0));
    check("arst_port1", VW'(to_sw_port1), VW'(0));
    check("arst_port2", VW'(to_sw_port2), VW'(0));
    check("arst_port3", VW'(to_sw_port3), VW'(0));
    check("arst_port4", VW'(to_sw_port4), VW'(0));
    check("arst_swap", VW'(swap_pulse), VW'(0));
    check("arst_active", active_words, model_bank());
    $display("async reset mid-copy sig=%0d", to_sw_sig);
    to_hw_sig = 2'b00;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    random_words();
    do_commit("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
